barrel_control: RTL and testbench

BARREL_CONTROL -- requirements
Module: barrel_control

---
 rtl/vgaPkg.sv | 54 +++++
 rtl/vga_if.sv | 15 +
 rtl/barrel_fsm.sv | 110 +++++++++++
 rtl/delay.sv | 26 ++
 rtl/barrel_control.sv | 130 +++++++++++++
 tb/tb_barrel_control.sv | 248 ++++++++++++++++++++++++
 6 files changed

// File: rtl/vgaPkg.sv
// Shared constants, types and helpers for the barrel sprite stage.
//   - coordinate/colour widths, spawn point, roll edge limits, exit column
//   - level y table (levels 0..3) via level_y()
//   - barrel FSM state enum and the packed VGA timing/rgb bus payload
package vgaPkg;

  localparam int unsigned COORD_W  = 11;
  localparam int unsigned RGB_W    = 12;
  localparam int unsigned SPRITE_W = 5;
  localparam int unsigned ADDR_W   = 2 * SPRITE_W;

  localparam logic [COORD_W-1:0] SPAWN_X     = 11'd160;
  localparam logic [COORD_W-1:0] SPAWN_Y     = 11'd96;
  localparam logic [COORD_W-1:0] LEFT_LIMIT  = 11'd160;
  localparam logic [COORD_W-1:0] RIGHT_LIMIT = 11'd800;
  localparam logic [COORD_W-1:0] EXIT_X      = 11'd64;
  localparam logic [COORD_W-1:0] FALL_STEP   = 11'd4;
  localparam logic [COORD_W-1:0] SPRITE_SIZE = 11'd32;
  localparam logic [1:0]         LAST_LEVEL  = 2'd3;

  localparam logic [RGB_W-1:0] TRANSPARENT_RGB = 12'h000;

  typedef enum logic [1:0] {
    IDLE,
    ROLL_RIGHT,
    ROLL_LEFT,
    FALL
  } barrel_state_e;

  typedef struct packed {
    logic [COORD_W-1:0] vcount;
    logic               vsync;
    logic               vblnk;
    logic [COORD_W-1:0] hcount;
    logic               hsync;
    logic               hblnk;
    logic [RGB_W-1:0]   rgb;
  } vga_bus_t;

  // Platform top y for each of the four levels.
  function automatic logic [COORD_W-1:0] level_y(input logic [1:0] level);
    logic [COORD_W-1:0] y;
    y = 11'd96;
    case (level)
      2'd0: y = 11'd96;
      2'd1: y = 11'd340;
      2'd2: y = 11'd556;
      2'd3: y = 11'd684;
      default: y = 11'd96;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/vga_if.sv
// VGA timing + colour stream between display stages.
//   modport in  : consumer view (all fields input)
//   modport out : producer view (all fields output)
interface vga_if;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/barrel_fsm.sv
// Barrel movement FSM: spawn counter, level tracking and sprite position.
// All updates happen on frame_tick_i; start_game_i low forces IDLE at once.
//   clk, rst (sync, active-low)
//   start_game_i, frame_tick_i       : control
//   state_o, x_o, y_o, active_o      : registered state / top-left position / valid
module barrel_fsm
  import vgaPkg::*;
#(
  parameter int unsigned SPAWN_FRAMES = 120,
  parameter int unsigned ROLL_STEP    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_game_i,
  input  logic               frame_tick_i,
  output barrel_state_e      state_o,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic               active_o
);

  localparam int unsigned CNT_W = $clog2(SPAWN_FRAMES + 1);
  localparam logic [COORD_W-1:0] STEP = COORD_W'(ROLL_STEP);

  barrel_state_e      state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         level_q, level_d;
  logic               active_q, active_d;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      cnt_q    <= '0;
      level_q  <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      active_q <= active_d;
    end
  end

  // Next state; level_q is the current platform, or the target while falling
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    level_d = level_q;

    if (!start_game_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (frame_tick_i) begin
      case (state_q)
        IDLE: begin
          if (cnt_q == CNT_W'(SPAWN_FRAMES - 1)) begin
            state_d = ROLL_RIGHT;
            x_d     = SPAWN_X;
            y_d     = SPAWN_Y;
            level_d = 2'd0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ROLL_RIGHT: begin
          x_d = x_q + STEP;
          if (x_d >= RIGHT_LIMIT) begin
            state_d = FALL;
            level_d = level_q + 2'd1;
          end
        end
        ROLL_LEFT: begin
          // Saturate rather than wrap below zero
          x_d = (x_q >= STEP) ? (x_q - STEP) : '0;
          if (level_q == LAST_LEVEL) begin
            if (x_d <= EXIT_X) state_d = IDLE;
          end else if (x_d <= LEFT_LIMIT) begin
            state_d = FALL;
            level_d = level_q + 2'd1;
          end
        end
        FALL: begin
          y_d = y_q + FALL_STEP;
          if (y_d >= level_y(level_q)) begin
            y_d     = level_y(level_q);
            state_d = level_q[0] ? ROLL_LEFT : ROLL_RIGHT;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    active_d = (state_d != IDLE);
  end

  assign state_o  = state_q;
  assign x_o      = x_q;
  assign y_o      = y_q;
  assign active_o = active_q;

endmodule

// File: rtl/delay.sv
// Generic fixed-latency register pipeline.
//   clk, rst (sync, active-low) ; din[WIDTH] -> dout[WIDTH] after CLK_DEL clocks
module delay #(
  parameter int unsigned WIDTH   = 1,
  parameter int unsigned CLK_DEL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe_q [CLK_DEL];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(CLK_DEL); i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= din;
      for (int i = 1; i < int'(CLK_DEL); i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign dout = pipe_q[CLK_DEL-1];

endmodule

// File: rtl/barrel_control.sv
// Barrel sprite stage: moves a barrel down the platforms and overlays it on
// the VGA stream. Stream latency is 3 clocks (2-clock delay + output reg).
// Optional feature: define BARREL_MIRROR_EN to mirror sprite columns while
// rolling left.
//   clk, rst (sync, active-low), start_game
//   rgb_pixel  : sprite ROM data (one-cycle latency after pixel_addr)
//   pixel_addr : sprite ROM address {row, col}
//   in / out   : VGA timing + rgb stream
//   barrel_x, barrel_y, barrel_active : position and valid for collision logic
module barrel_control
  import vgaPkg::*;
#(
  parameter int unsigned SPAWN_FRAMES = 120,
  parameter int unsigned ROLL_STEP    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_game,
  input  logic [RGB_W-1:0]   rgb_pixel,
  output logic [ADDR_W-1:0]  pixel_addr,
  vga_if.in                  in,
  vga_if.out                 out,
  output logic [COORD_W-1:0] barrel_x,
  output logic [COORD_W-1:0] barrel_y,
  output logic               barrel_active
);

  vga_bus_t           bus_in, bus_buf;
  barrel_state_e      state;
  logic [COORD_W-1:0] x, y;
  logic               origin_q, frame_tick_q;
  logic               origin_c, in_box_c, hit_c;
  logic [SPRITE_W-1:0] row_c, col_c;

  always_comb begin
    bus_in.vcount = in.vcount;
    bus_in.vsync  = in.vsync;
    bus_in.vblnk  = in.vblnk;
    bus_in.hcount = in.hcount;
    bus_in.hsync  = in.hsync;
    bus_in.hblnk  = in.hblnk;
    bus_in.rgb    = in.rgb;
  end

  delay #(
    .WIDTH   ($bits(vga_bus_t)),
    .CLK_DEL (2)
  ) u_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (bus_in),
    .dout (bus_buf)
  );

  // One-clock pulse on arrival at the frame origin (edge-detected)
  assign origin_c = (in.vcount == '0) && (in.hcount == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      origin_q     <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      origin_q     <= origin_c;
      frame_tick_q <= origin_c && !origin_q;
    end
  end

  barrel_fsm #(
    .SPAWN_FRAMES (SPAWN_FRAMES),
    .ROLL_STEP    (ROLL_STEP)
  ) u_fsm (
    .clk          (clk),
    .rst          (rst),
    .start_game_i (start_game),
    .frame_tick_i (frame_tick_q),
    .state_o      (state),
    .x_o          (x),
    .y_o          (y),
    .active_o     (barrel_active)
  );

  assign barrel_x = x;
  assign barrel_y = y;

  // ROM address from the undelayed stream so data lines up with the delayed one
  always_comb begin
    in_box_c = (in.hcount >= x) && (in.hcount < x + SPRITE_SIZE) &&
               (in.vcount >= y) && (in.vcount < y + SPRITE_SIZE);
    row_c    = SPRITE_W'(in.vcount - y);
    col_c    = SPRITE_W'(in.hcount - x);
`ifdef BARREL_MIRROR_EN
    if (state == ROLL_LEFT) col_c = 5'd31 - col_c;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pixel_addr <= '0;
    end else if (in_box_c) begin
      pixel_addr <= {row_c, col_c};
    end
  end

  // Sprite hit on the delayed stream
  assign hit_c = (state != IDLE) && start_game &&
                 !(bus_buf.hblnk || bus_buf.vblnk) &&
                 (bus_buf.hcount >= x) && (bus_buf.hcount < x + SPRITE_SIZE) &&
                 (bus_buf.vcount >= y) && (bus_buf.vcount < y + SPRITE_SIZE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      out.vcount <= '0;
      out.vsync  <= 1'b0;
      out.vblnk  <= 1'b0;
      out.hcount <= '0;
      out.hsync  <= 1'b0;
      out.hblnk  <= 1'b0;
      out.rgb    <= '0;
    end else begin
      out.vcount <= bus_buf.vcount;
      out.vsync  <= bus_buf.vsync;
      out.vblnk  <= bus_buf.vblnk;
      out.hcount <= bus_buf.hcount;
      out.hsync  <= bus_buf.hsync;
      out.hblnk  <= bus_buf.hblnk;
      out.rgb    <= (hit_c && (rgb_pixel != TRANSPARENT_RGB)) ? rgb_pixel : bus_buf.rgb;
    end
  end

endmodule

// File: tb/tb_barrel_control.sv
// Directed testbench for barrel_control (SPAWN_FRAMES=4, ROLL_STEP=2).
module tb_barrel_control;

  logic        clk;
  logic        rst;
  logic        start_game;
  logic [11:0] rgb_pixel;
  logic [9:0]  pixel_addr;
  logic [10:0] barrel_x, barrel_y;
  logic        barrel_active;

  vga_if vin ();
  vga_if vout ();

  barrel_control #(
    .SPAWN_FRAMES (4),
    .ROLL_STEP    (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_game    (start_game),
    .rgb_pixel     (rgb_pixel),
    .pixel_addr    (pixel_addr),
    .in            (vin),
    .out           (vout),
    .barrel_x      (barrel_x),
    .barrel_y      (barrel_y),
    .barrel_active (barrel_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [10:0] h;
    logic [10:0] v;
    logic        hb;
    logic        vb;
    logic [11:0] rin;
    logic [11:0] rpix;
    logic [11:0] exp_rgb;
    logic [9:0]  exp_addr;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One frame_tick: origin for one clock, then leave it; FSM updates on the 2nd edge
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      vin.hcount = 11'd0;
      vin.vcount = 11'd0;
      step(1);
      vin.hcount = 11'd1;
      step(1);
    end
  endtask

  task automatic drive(input logic [10:0] h, input logic [10:0] v, input logic hb,
                       input logic vb, input logic [11:0] rin, input logic [11:0] rpix);
    vin.hcount = h;
    vin.vcount = v;
    vin.hblnk  = hb;
    vin.vblnk  = vb;
    vin.rgb    = rin;
    rgb_pixel  = rpix;
  endtask

  task automatic park();
    drive(11'd1, 11'd0, 1'b0, 1'b0, 12'h000, 12'h000);
  endtask

  initial begin
    // Barrel spawned at (160,96) rolling right for all table vectors
    vecs[0] = '{11'd165, 11'd103, 1'b0, 1'b0, 12'h0F0, 12'hF00, 12'hF00, 10'd229};
    vecs[1] = '{11'd165, 11'd103, 1'b0, 1'b0, 12'h0F0, 12'h000, 12'h0F0, 10'd229};
    vecs[2] = '{11'd160, 11'd96,  1'b0, 1'b0, 12'h111, 12'h00F, 12'h00F, 10'd0};
    vecs[3] = '{11'd191, 11'd127, 1'b0, 1'b0, 12'h456, 12'h123, 12'h123, 10'd1023};
    vecs[4] = '{11'd192, 11'd127, 1'b0, 1'b0, 12'h456, 12'h123, 12'h456, 10'd1023};
    vecs[5] = '{11'd159, 11'd100, 1'b0, 1'b0, 12'h789, 12'h123, 12'h789, 10'd1023};
    vecs[6] = '{11'd170, 11'd128, 1'b0, 1'b0, 12'hABC, 12'h123, 12'hABC, 10'd1023};
    vecs[7] = '{11'd170, 11'd100, 1'b1, 1'b0, 12'h222, 12'hF00, 12'h222, 10'd138};
    vecs[8] = '{11'd170, 11'd100, 1'b0, 1'b1, 12'h333, 12'hF00, 12'h333, 10'd138};
    vecs[9] = '{11'd175, 11'd110, 1'b0, 1'b0, 12'h000, 12'hFFF, 12'hFFF, 10'd463};

    rst        = 1'b0;
    start_game = 1'b0;
    vin.vsync  = 1'b0;
    vin.hsync  = 1'b0;
    drive(11'd5, 11'd5, 1'b0, 1'b0, 12'hABC, 12'h000);

    // Reset state
    step(2);
    check("rst_out_rgb", 32'(vout.rgb), 0);
    check("rst_out_hcount", 32'(vout.hcount), 0);
    check("rst_addr", 32'(pixel_addr), 0);
    check("rst_active", 32'(barrel_active), 0);
    check("rst_x", 32'(barrel_x), 0);
    check("rst_y", 32'(barrel_y), 0);

    // Spawn after the 4th tick
    park();
    rst        = 1'b1;
    start_game = 1'b1;
    tick(3);
    check("spawn_early_active", 32'(barrel_active), 0);
    tick(1);
    check("spawn_active", 32'(barrel_active), 1);
    check("spawn_x", 32'(barrel_x), 160);
    check("spawn_y", 32'(barrel_y), 96);

    // Pixel vectors held for 3 clocks each
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].h, vecs[i].v, vecs[i].hb, vecs[i].vb, vecs[i].rin, vecs[i].rpix);
      step(3);
      check($sformatf("vec%0d_rgb", i), 32'(vout.rgb), 32'(vecs[i].exp_rgb));
      check($sformatf("vec%0d_addr", i), 32'(pixel_addr), 32'(vecs[i].exp_addr));
      check($sformatf("vec%0d_hcount", i), 32'(vout.hcount), 32'(vecs[i].h));
    end

    // Exact 3-clock latency for a single in-box pixel
    drive(11'd300, 11'd300, 1'b0, 1'b0, 12'h0F0, 12'hF00);
    step(3);
    drive(11'd165, 11'd103, 1'b0, 1'b0, 12'h0F0, 12'hF00);
    step(1);
    check("lat_addr", 32'(pixel_addr), 229);
    drive(11'd300, 11'd300, 1'b0, 1'b0, 12'h0F0, 12'hF00);
    step(1);
    check("lat_early", 32'(vout.rgb), 'h0F0);
    step(1);
    check("lat_hit", 32'(vout.rgb), 'hF00);
    step(1);
    check("lat_after", 32'(vout.rgb), 'h0F0);
    park();

    // Level 0 roll and fall to level 1
    tick(319);
    check("l0_x798", 32'(barrel_x), 798);
    tick(1);
    check("l0_x800", 32'(barrel_x), 800);
    tick(1);
    check("fall1_y100", 32'(barrel_y), 100);
    check("fall1_x_hold", 32'(barrel_x), 800);
    tick(60);
    check("l1_y340", 32'(barrel_y), 340);
    tick(1);
    check("l1_left_x798", 32'(barrel_x), 798);

    // Column mirroring while rolling left
    drive(11'd803, 11'd347, 1'b0, 1'b0, 12'h0F0, 12'hF00);
    step(3);
    check("left_rgb", 32'(vout.rgb), 'hF00);
`ifdef BARREL_MIRROR_EN
    check("left_addr", 32'(pixel_addr), 250);
`else
    check("left_addr", 32'(pixel_addr), 229);
`endif
    park();

    // Level 1 -> level 2 -> level 3
    tick(319);
    check("l1_x160", 32'(barrel_x), 160);
    tick(54);
    check("l2_y556", 32'(barrel_y), 556);
    tick(1);
    check("l2_x162", 32'(barrel_x), 162);
    tick(319);
    check("l2_x800", 32'(barrel_x), 800);
    tick(32);
    check("l3_y684", 32'(barrel_y), 684);

    // Level 3 exit at x=64 and respawn
    tick(367);
    check("l3_x66", 32'(barrel_x), 66);
    check("l3_active", 32'(barrel_active), 1);
    tick(1);
    check("exit_x64", 32'(barrel_x), 64);
    check("exit_inactive", 32'(barrel_active), 0);
    tick(3);
    check("respawn_early", 32'(barrel_active), 0);
    tick(1);
    check("respawn_active", 32'(barrel_active), 1);
    check("respawn_x", 32'(barrel_x), 160);
    check("respawn_y", 32'(barrel_y), 96);

    // Drop start_game while falling
    tick(320);
    tick(10);
    check("fall_y136", 32'(barrel_y), 136);
    start_game = 1'b0;
    step(1);
    check("drop_inactive", 32'(barrel_active), 0);
    drive(11'd805, 11'd140, 1'b0, 1'b0, 12'h0F0, 12'hF00);
    step(3);
    check("drop_pass0", 32'(vout.rgb), 'h0F0);
    drive(11'd810, 11'd150, 1'b0, 1'b0, 12'h123, 12'hF00);
    step(3);
    check("drop_pass1", 32'(vout.rgb), 'h123);
    drive(11'd900, 11'd600, 1'b1, 1'b0, 12'h456, 12'hF00);
    step(3);
    check("drop_pass2", 32'(vout.rgb), 'h456);
    park();
    tick(5);
    check("drop_no_spawn", 32'(barrel_active), 0);

    // Spawn counter restarts from zero
    start_game = 1'b1;
    tick(3);
    check("restart_early", 32'(barrel_active), 0);
    tick(1);
    check("restart_active", 32'(barrel_active), 1);
    check("restart_x", 32'(barrel_x), 160);

    // Reset coinciding with frame_tick
    vin.hcount = 11'd0;
    vin.vcount = 11'd0;
    step(1);
    vin.hcount = 11'd1;
    rst = 1'b0;
    step(1);
    check("rst_tick_x", 32'(barrel_x), 0);
    check("rst_tick_y", 32'(barrel_y), 0);
    check("rst_tick_active", 32'(barrel_active), 0);
    check("rst_tick_rgb", 32'(vout.rgb), 0);
    check("rst_tick_addr", 32'(pixel_addr), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
